// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the unified memory arbiter
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} arb_state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} arb_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of DM grants made while IF waits
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port memory between fetch and data stages
module unified_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = XLEN,
  parameter int DATA_W     = XLEN,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                err_timeout,
  output logic                err_spur
);

  localparam int BE_W = DATA_W / 8;
  localparam int TW   = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                err_tmo_q, err_tmo_d;
  logic                err_spur_q, err_spur_d;
  logic                issue, grant_if, grant_dm, starve_sat;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (grant_dm & if_req),
    .clr_i (grant_if | ~if_req),
    .sat_o (starve_sat)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_tmo_d   = err_tmo_q;
    err_spur_d  = err_spur_q;
    issue       = 1'b0;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_rvalid) err_spur_d = 1'b1;
        // No issue during a response pulse: the requester still shows the request it just completed.
        if (rst && !(if_rvalid_q || dm_rvalid_q) && (if_req || dm_req)) begin
          issue    = 1'b1;
          grant_dm = dm_req && !(if_req && starve_sat);
          grant_if = !grant_dm;
          owner_d  = grant_dm ? OWN_DM : OWN_IF;
          we_d     = grant_dm & dm_we;
          addr_d   = grant_dm ? dm_addr : if_addr;
          tmo_d    = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            dm_rvalid_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      tmo_q       <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_tmo_q   <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      tmo_q       <= tmo_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_tmo_q   <= err_tmo_d;
      err_spur_q  <= err_spur_d;
    end
  end

  assign mem_req     = issue;
  assign mem_we      = grant_dm & dm_we;
  assign mem_addr    = grant_dm ? dm_addr : (grant_if ? if_addr : '0);
  assign mem_wdata   = grant_dm ? dm_wdata : '0;
  assign mem_be      = grant_dm ? dm_be : (grant_if ? {BE_W{1'b1}} : '0);
  assign if_rvalid   = if_rvalid_q;
  assign dm_rvalid   = dm_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign stall_if    = if_req & ~if_rvalid_q;
  assign stall_mem   = dm_req & ~dm_rvalid_q;
  assign err_timeout = err_tmo_q;
  assign err_spur    = err_spur_q;

  // A held request must keep its address until its response arrives.
  a_if_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ST_WAIT && owner_q == OWN_IF && if_req) |-> (if_addr == addr_q));
  a_dm_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ST_WAIT && owner_q == OWN_DM && dm_req) |-> (dm_addr == addr_q));

endmodule
